// File: rtl/jmb_dad_pipe.sv
// -----------------------------------------------------------------------------
// jmb_dad_pipe
//   Two-stage pipelined signed add / round / arithmetic-shift / saturate
//   datapath with valid/ready handshakes on both sides and a sticky
//   saturation event counter.
//
//   out = sat((add_1 + add_2 [+ 2**(shift-1)]) >>> shift)
//
// Parameters
//   WIDTH     operand and result width (signed, >= 4)
//   SHIFT_W   width of the shift amount
//   SATURATE  1: clamp to the WIDTH signed range, 0: wrap (drop MSBs)
//   CNT_W     saturation event counter width
//
// Ports
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (in_ready is combinational)
//   add_1, add_2          signed operands
//   shift, round_en       shift amount and round-half-up enable
//   out_valid / out_ready output handshake
//   out, sat              result and its clamp/wrap flag (qualified by out_valid)
//   sat_count, cnt_clr    delivered saturated beats (sticky at all-ones), clear
// -----------------------------------------------------------------------------
module jmb_dad_pipe #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned SHIFT_W  = 5,
    parameter bit          SATURATE = 1'b1,
    parameter int unsigned CNT_W    = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   add_1,
    input  logic [WIDTH-1:0]   add_2,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               round_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out,
    output logic               sat,
    output logic [CNT_W-1:0]   sat_count,
    input  logic               cnt_clr
);

    // Rounding/shift datapath width: exact sum (WIDTH+1) plus one bit of
    // headroom so that adding the rounding constant can never overflow.
    localparam int unsigned RW = WIDTH + 2;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic               s1_valid_q, s1_valid_d;
    logic [WIDTH:0]     s1_sum_q,   s1_sum_d;
    logic [SHIFT_W-1:0] s1_shift_q, s1_shift_d;
    logic               s1_round_q, s1_round_d;

    logic               s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]   out_q,      out_d;
    logic               sat_q,      sat_d;

    logic [CNT_W-1:0]   cnt_q,      cnt_d;

    // ---------------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------------
    logic s1_load;
    logic s2_load;
    logic deliver;

    always_comb begin
        s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
        in_ready = !s1_valid_q || s2_load;
        s1_load  = in_valid && in_ready;
        deliver  = s2_valid_q && out_ready;
    end

    // ---------------------------------------------------------------------
    // Stage 1: exact sum, shift and round control captured together
    // ---------------------------------------------------------------------
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sum_d   = s1_sum_q;
        s1_shift_d = s1_shift_q;
        s1_round_d = s1_round_q;
        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_sum_d   = {add_1[WIDTH-1], add_1} + {add_2[WIDTH-1], add_2};
            s1_shift_d = shift;
            s1_round_d = round_en;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Stage 2: round, shift, range check
    // ---------------------------------------------------------------------
    logic [RW-1:0]    r_ext;
    logic [RW-1:0]    rnd_add;
    logic [RW-1:0]    r_sum;
    logic [RW-1:0]    q_full;
    logic             big_shift;
    logic             fits;
    logic [WIDTH-1:0] res;

    always_comb begin
        r_ext     = {s1_sum_q[WIDTH], s1_sum_q};
        big_shift = (32'(s1_shift_q) >= RW);

        rnd_add = '0;
        if (s1_round_q && (s1_shift_q != '0) && !big_shift) begin
            rnd_add = RW'(1) << (s1_shift_q - SHIFT_W'(1));
        end
        r_sum = r_ext + rnd_add;

        // A shift past the datapath width leaves only sign bits. With
        // rounding the constant 2**(shift-1) exceeds |sum|, so the exact
        // rounded value is non-negative and shifts out to zero.
        if (big_shift) begin
            q_full = s1_round_q ? '0 : {RW{r_ext[RW-1]}};
        end else begin
            q_full = $signed(r_sum) >>> s1_shift_q;
        end

        // q fits in WIDTH bits when all bits from WIDTH-1 upward agree.
        fits = (&q_full[RW-1:WIDTH-1]) || !(|q_full[RW-1:WIDTH-1]);

        res = q_full[WIDTH-1:0];
        if (SATURATE && !fits) begin
            res = q_full[RW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        out_d      = out_q;
        sat_d      = sat_q;
        if (s2_load) begin
            s2_valid_d = 1'b1;
            out_d      = res;
            sat_d      = !fits;
        end else if (deliver) begin
            s2_valid_d = 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Saturation event counter (clear wins over a same-cycle increment)
    // ---------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (deliver && sat_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_shift_q <= '0;
            s1_round_q <= 1'b0;
            s2_valid_q <= 1'b0;
            out_q      <= '0;
            sat_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sum_q   <= s1_sum_d;
            s1_shift_q <= s1_shift_d;
            s1_round_q <= s1_round_d;
            s2_valid_q <= s2_valid_d;
            out_q      <= out_d;
            sat_q      <= sat_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out       = out_q;
    assign sat       = sat_q;
    assign sat_count = cnt_q;

endmodule

// File: tb/tb_jmb_dad_pipe.sv
module tb_jmb_dad_pipe;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready, in_ready_w;
    logic [15:0] add_1, add_2;
    logic [4:0]  shift;
    logic        round_en;
    logic        out_valid, out_valid_w;
    logic        out_ready;
    logic [15:0] out, out_w;
    logic        sat, sat_w;
    logic [7:0]  sat_count, sat_count_w;
    logic        cnt_clr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    jmb_dad_pipe #(.WIDTH(16), .SHIFT_W(5), .SATURATE(1'b1), .CNT_W(8)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .add_1(add_1), .add_2(add_2), .shift(shift), .round_en(round_en),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .sat(sat),
        .sat_count(sat_count), .cnt_clr(cnt_clr)
    );

    jmb_dad_pipe #(.WIDTH(16), .SHIFT_W(5), .SATURATE(1'b0), .CNT_W(8)) dut_w (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .add_1(add_1), .add_2(add_2), .shift(shift), .round_en(round_en),
        .out_valid(out_valid_w), .out_ready(out_ready), .out(out_w), .sat(sat_w),
        .sat_count(sat_count_w), .cnt_clr(cnt_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [4:0]  sh;
        logic        rnd;
        logic [15:0] exp_s;
        logic        sat_s;
        logic [15:0] exp_w;
        logic        sat_w;
    } vec_t;

    localparam int NV = 14;
    vec_t vec [NV];

    int exp_cnt, exp_cnt_w;

    initial begin
        // a, b, shift, round, sat-build out/sat, wrap-build out/sat
        vec[0]  = '{16'h000F, 16'h0002, 5'd0,  1'b0, 16'h0011, 1'b0, 16'h0011, 1'b0};
        vec[1]  = '{16'h000F, 16'h0002, 5'd1,  1'b0, 16'h0008, 1'b0, 16'h0008, 1'b0};
        vec[2]  = '{16'hFFF1, 16'h0002, 5'd1,  1'b0, 16'hFFF9, 1'b0, 16'hFFF9, 1'b0};
        vec[3]  = '{16'hFFF1, 16'h0002, 5'd1,  1'b1, 16'hFFFA, 1'b0, 16'hFFFA, 1'b0};
        vec[4]  = '{16'h0011, 16'h0000, 5'd1,  1'b1, 16'h0009, 1'b0, 16'h0009, 1'b0};
        vec[5]  = '{16'h7FFF, 16'h0001, 5'd0,  1'b0, 16'h7FFF, 1'b1, 16'h8000, 1'b1};
        vec[6]  = '{16'h7FFF, 16'h0001, 5'd1,  1'b0, 16'h4000, 1'b0, 16'h4000, 1'b0};
        vec[7]  = '{16'h8000, 16'h8000, 5'd0,  1'b0, 16'h8000, 1'b1, 16'h0000, 1'b1};
        vec[8]  = '{16'h8000, 16'hFFFF, 5'd31, 1'b0, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0};
        vec[9]  = '{16'h1234, 16'h0100, 5'd4,  1'b1, 16'h0133, 1'b0, 16'h0133, 1'b0};
        vec[10] = '{16'h7FFF, 16'h7FFF, 5'd1,  1'b1, 16'h7FFF, 1'b0, 16'h7FFF, 1'b0};
        vec[11] = '{16'h7FFF, 16'h7FFF, 5'd0,  1'b0, 16'h7FFF, 1'b1, 16'hFFFE, 1'b1};
        vec[12] = '{16'h0001, 16'h0000, 5'd1,  1'b1, 16'h0001, 1'b0, 16'h0001, 1'b0};
        vec[13] = '{16'h8000, 16'h8000, 5'd17, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0};

        reset_n = 1'b0; in_valid = 1'b0; add_1 = '0; add_2 = '0; shift = '0;
        round_en = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        exp_cnt = 0; exp_cnt_w = 0;

        // ---------------- reset state ----------------
        #12;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out", 32'(out), 32'd0);
        check("rst sat", 32'(sat), 32'd0);
        check("rst sat_count", 32'(sat_count), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        @(negedge clock);
        reset_n = 1'b1;

        // ---------------- directed vectors ----------------
        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            in_valid = 1'b1; add_1 = vec[i].a; add_2 = vec[i].b;
            shift = vec[i].sh; round_en = vec[i].rnd; out_ready = 1'b1;
            #1 check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'd1);
            @(posedge clock);
            @(negedge clock);
            in_valid = 1'b0; add_1 = 16'hA5A5; add_2 = 16'h5A5A; shift = 5'd3; round_en = 1'b1;
            check($sformatf("v%0d early out_valid", i), 32'(out_valid), 32'd0);
            @(posedge clock);
            #1;
            check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("v%0d out", i), 32'(out), 32'(vec[i].exp_s));
            check($sformatf("v%0d sat", i), 32'(sat), 32'(vec[i].sat_s));
            check($sformatf("v%0d wrap out", i), 32'(out_w), 32'(vec[i].exp_w));
            check($sformatf("v%0d wrap sat", i), 32'(sat_w), 32'(vec[i].sat_w));
            if (vec[i].sat_s) exp_cnt++;
            if (vec[i].sat_w) exp_cnt_w++;
            @(posedge clock);
            #1;
            check($sformatf("v%0d drained", i), 32'(out_valid), 32'd0);
            check($sformatf("v%0d sat_count", i), 32'(sat_count), 32'(exp_cnt));
            check($sformatf("v%0d wrap sat_count", i), 32'(sat_count_w), 32'(exp_cnt_w));
        end

        // ---------------- backpressure stream ----------------
        begin
            int sent, got, infl;
            logic prev_stall, acc, dlv;
            logic [15:0] prev_out;
            sent = 0; got = 0; infl = 0; prev_stall = 1'b0; prev_out = '0;
            for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
                @(negedge clock);
                out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                shift = 5'd0; round_en = 1'b0;
                if (sent < 8) begin
                    in_valid = 1'b1; add_1 = 16'(sent * 3 + 1); add_2 = 16'(sent);
                end else begin
                    in_valid = 1'b0;
                end
                #1;
                if (prev_stall) begin
                    check("bp hold valid", 32'(out_valid), 32'd1);
                    check("bp hold out", 32'(out), 32'(prev_out));
                end
                check("bp in_ready", 32'(in_ready), 32'(!(infl == 2 && !out_ready)));
                acc = in_valid && in_ready;
                dlv = out_valid && out_ready;
                if (dlv) begin
                    check($sformatf("bp beat%0d", got), 32'(out), 32'(got * 4 + 1));
                    got++;
                end
                prev_stall = out_valid && !out_ready;
                prev_out   = out;
                if (acc) sent++;
                infl = infl + int'(acc) - int'(dlv);
            end
            check("bp all delivered", 32'(got), 32'd8);
            @(negedge clock);
            in_valid = 1'b0; out_ready = 1'b1;
            @(posedge clock); #1;
            check("bp empty", 32'(out_valid), 32'd0);
        end

        // ---------------- counter saturation ----------------
        @(negedge clock); cnt_clr = 1'b1;
        @(posedge clock); #1 check("clr", 32'(sat_count), 32'd0);
        @(negedge clock);
        cnt_clr = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; add_1 = 16'h7FFF; add_2 = 16'h0001; shift = 5'd0; round_en = 1'b0;
        begin
            int acc_n;
            logic ok;
            acc_n = 0;
            for (int c = 0; c < 400 && acc_n < 300; c++) begin
                #1 ok = in_ready;
                @(posedge clock);
                if (ok) acc_n++;
                @(negedge clock);
                if (acc_n >= 300) in_valid = 1'b0;
            end
            in_valid = 1'b0;
            check("cnt beats accepted", 32'(acc_n), 32'd300);
        end
        repeat (4) @(posedge clock);
        #1;
        check("cnt sticky", 32'(sat_count), 32'hFF);
        check("cnt sticky wrap", 32'(sat_count_w), 32'hFF);

        // clear coincident with a saturated delivery
        @(negedge clock);
        out_ready = 1'b0; in_valid = 1'b1; add_1 = 16'h8000; add_2 = 16'h8000;
        @(posedge clock);
        @(negedge clock); in_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        #1 check("clr+inc held", 32'(out_valid), 32'd1);
        check("clr+inc sat", 32'(sat), 32'd1);
        cnt_clr = 1'b1; out_ready = 1'b1;
        @(posedge clock); #1;
        check("clr+inc count", 32'(sat_count), 32'd0);
        check("clr+inc drained", 32'(out_valid), 32'd0);
        @(negedge clock); cnt_clr = 1'b0;

        // ---------------- reset mid-stream ----------------
        in_valid = 1'b1; add_1 = 16'h7FFF; add_2 = 16'h7FFF; shift = 5'd0;
        @(posedge clock);
        @(negedge clock); in_valid = 1'b0;
        @(posedge clock);
        @(posedge clock); #1;
        check("pre-rst count", 32'(sat_count), 32'd1);
        @(negedge clock);
        out_ready = 1'b0; in_valid = 1'b1; add_1 = 16'h0005; add_2 = 16'h0000;
        @(posedge clock);
        @(negedge clock);
        add_1 = 16'h0006;
        #1 check("mid in_ready", 32'(in_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        check("full out_valid", 32'(out_valid), 32'd1);
        check("full out", 32'(out), 32'h0005);
        check("full in_ready", 32'(in_ready), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("mid-rst out_valid", 32'(out_valid), 32'd0);
        check("mid-rst out_valid wrap", 32'(out_valid_w), 32'd0);
        check("mid-rst sat_count", 32'(sat_count), 32'd0);
        check("mid-rst out", 32'(out), 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            check($sformatf("post-rst idle%0d", c), 32'(out_valid), 32'd0);
        end
        @(negedge clock);
        in_valid = 1'b1; add_1 = 16'h0003; add_2 = 16'h0004; shift = 5'd0; round_en = 1'b0;
        @(posedge clock);
        @(negedge clock); in_valid = 1'b0;
        check("post-rst early", 32'(out_valid), 32'd0);
        @(posedge clock); #1;
        check("post-rst out_valid", 32'(out_valid), 32'd1);
        check("post-rst out", 32'(out), 32'h0007);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
